// File: rtl/rgb_sequencer.sv
// rgb_sequencer: steps a one-hot RGB indicator through RED -> GREEN -> BLUE.
// Each colour is held for its own programmable dwell time.
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous, active-high reset
//   start     begin a sequence (only honoured in IDLE)
//   stop      abort to IDLE on the next edge
//   en        count enable; low pauses the state and the dwell counter
//   mode      0 = loop BLUE -> RED, 1 = single pass BLUE -> IDLE
//   cfg_we    dwell register write strobe
//   cfg_sel   0 red, 1 green, 2 blue, 3 none
//   cfg_data  dwell value to write
//   light     one-hot colour: RED 100, GREEN 010, BLUE 001, IDLE 000
//   busy      high while a colour is shown
//   done      one-cycle pulse in the first IDLE cycle after a single pass
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | light off, waiting for start
// RED   | showing red, counter counts down dw_r
// GREEN | showing green, counter counts down dw_g
// BLUE  | showing blue, counter counts down dw_b; exit per mode
module rgb_sequencer #(
   parameter int          CW        = 8,
   parameter int unsigned DEF_DWELL = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          en,
   input  logic          mode,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_sel,
   input  logic [CW-1:0] cfg_data,
   output logic [2:0]    light,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RED   = 2'd1,
      S_GREEN = 2'd2,
      S_BLUE  = 2'd3
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] dw_r, dw_g, dw_b;
   logic          done_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         done  <= 1'b0;
         dw_r  <= CW'(DEF_DWELL);
         dw_g  <= CW'(DEF_DWELL);
         dw_b  <= CW'(DEF_DWELL);
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         done  <= done_n;
         // A colour entered on this same edge has already sampled the old
         // value through cnt_n, so no bypass is needed here.
         if (cfg_we) begin
            case (cfg_sel)
               2'd0:    dw_r <= cfg_data;
               2'd1:    dw_g <= cfg_data;
               2'd2:    dw_b <= cfg_data;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done_n  = 1'b0;
      if (stop) begin
         state_n = S_IDLE;
         cnt_n   = '0;
      end else if (state == S_IDLE) begin
         if (start) begin
            state_n = S_RED;
            cnt_n   = dw_r;
         end
      end else if (en) begin
         if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
         end else begin
            case (state)
               S_RED: begin
                  state_n = S_GREEN;
                  cnt_n   = dw_g;
               end
               S_GREEN: begin
                  state_n = S_BLUE;
                  cnt_n   = dw_b;
               end
               S_BLUE: begin
                  if (mode) begin
                     state_n = S_IDLE;
                     cnt_n   = '0;
                     done_n  = 1'b1;
                  end else begin
                     state_n = S_RED;
                     cnt_n   = dw_r;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Outputs decode straight from the state register so they only change
   // with the state itself.
   always_comb begin
      case (state)
         S_RED:   light = 3'b100;
         S_GREEN: light = 3'b010;
         S_BLUE:  light = 3'b001;
         default: light = 3'b000;
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_rgb_sequencer.sv
// Bench for rgb_sequencer: a table of per-cycle stimulus with expected
// outputs, replayed through a scoreboard queue, plus a hand-written
// maximum-dwell sequence.
module tb_rgb_sequencer;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] GRN = 3'b010;
   localparam logic [2:0] BLU = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   logic       clk = 1'b0;
   logic       rst, start, stop, en, mode, cfg_we;
   logic [1:0] cfg_sel;
   logic [7:0] cfg_data;
   logic [2:0] light;
   logic       busy, done;

   always #5 clk = ~clk;

   rgb_sequencer #(.CW(8), .DEF_DWELL(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .en       (en),
      .mode     (mode),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .light    (light),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      logic       rst, start, stop, en, mode, we;
      logic [1:0] sel;
      logic [7:0] data;
      logic [2:0] light;
      logic       busy, done;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic add(input logic r, s, p, e, m, w, input logic [1:0] sl, input logic [7:0] d,
                      input logic [2:0] l, input logic b, dn);
      vec_t v;
      v.rst = r; v.start = s; v.stop = p; v.en = e; v.mode = m; v.we = w;
      v.sel = sl; v.data = d; v.light = l; v.busy = b; v.done = dn;
      tbl.push_back(v);
   endtask

   task automatic add_idle();
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, OFF, 1'b0, 1'b0);
   endtask

   task automatic add_cfg(input logic [1:0] sl, input logic [7:0] d);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, sl, d, OFF, 1'b0, 1'b0);
   endtask

   // Single pass with en high; optional stray start pulses during RED.
   task automatic add_pass(input int nr, input int ng, input int nb, input bit sir);
      for (int i = 0; i < nr; i++)
         add(1'b0, (i == 0) || (sir && (i == 2 || i == 3)), 1'b0, 1'b1, 1'b1, 1'b0,
             2'd0, 8'd0, RED, 1'b1, 1'b0);
      for (int i = 0; i < ng; i++)
         add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, GRN, 1'b1, 1'b0);
      for (int i = 0; i < nb; i++)
         add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, BLU, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, OFF, 1'b0, 1'b1);
   endtask

   initial begin
      int n, k;

      // Defaults after reset: single pass, 5 cycles per colour.
      add_pass(5, 5, 5, 1'b0);
      add_idle();

      // Program dwells r=0 g=2 b=1 (sel 3 must not touch anything), loop mode,
      // then stop while in BLUE.
      add_cfg(2'd0, 8'd0);
      add_cfg(2'd1, 8'd2);
      add_cfg(2'd2, 8'd1);
      add_cfg(2'd3, 8'd9);
      for (int j = 0; j < 17; j++) begin
         int p;
         p = j % 6;
         add(1'b0, j == 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0,
             (p == 0) ? RED : ((p < 4) ? GRN : BLU), 1'b1, 1'b0);
      end
      add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, OFF, 1'b0, 1'b0);
      add_idle();

      // start and stop together in IDLE.
      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, OFF, 1'b0, 1'b0);
      add_idle();

      // Pause: green dwell 4, en low 3 cycles -> 8 GREEN cycles. start with en low.
      add_cfg(2'd1, 8'd4);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, RED, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, GRN, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, GRN, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, GRN, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, GRN, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++)
         add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, BLU, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, OFF, 1'b0, 1'b1);
      add_idle();

      // Write dw_g=0 on the RED->GREEN edge: this GREEN still uses 4.
      // Then restart in the done cycle: next pass has 1 cycle of GREEN.
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, RED, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'd0, GRN, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, GRN, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++)
         add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, BLU, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, OFF, 1'b0, 1'b1);
      add_pass(1, 1, 2, 1'b0);
      add_idle();

      // Reset in GREEN after dw_g=9; defaults restored, stray starts in RED,
      // then stop in IDLE has no effect.
      add_cfg(2'd1, 8'd9);
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, RED, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, GRN, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, GRN, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, OFF, 1'b0, 1'b0);
      add_pass(5, 5, 5, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, OFF, 1'b0, 1'b0);
      add_idle();

      rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1; mode = 1'b1;
      cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'({light, busy, done}), 32'({OFF, 1'b0, 1'b0}));

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v, e;
         @(negedge clk);
         v = tbl[i];
         rst = v.rst; start = v.start; stop = v.stop; en = v.en; mode = v.mode;
         cfg_we = v.we; cfg_sel = v.sel; cfg_data = v.data;
         exp_q.push_back(v);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("row%0d light/busy/done", i), 32'({light, busy, done}),
               32'({e.light, e.busy, e.done}));
      end

      // Maximum dwell: 255 -> 256 RED cycles.
      @(negedge clk);
      rst = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b1; mode = 1'b1;
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd255;
      @(negedge clk);
      cfg_sel = 2'd1; cfg_data = 8'd0;
      @(negedge clk);
      cfg_sel = 2'd2; cfg_data = 8'd0;
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      while (light == RED && n < 400) begin
         n++;
         @(posedge clk);
         #1;
      end
      check("max_dwell_red_cycles", 32'(n), 32'd256);
      check("max_dwell_then_green", 32'(light), 32'(GRN));
      k = 0;
      while (!done && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("max_pass_done_latency", 32'(k), 32'd2);
      check("max_pass_done_idle", 32'({light, busy, done}), 32'({OFF, 1'b0, 1'b1}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
